// File: rtl/demux_dispatcher_pkg.sv
// demux_dispatcher_pkg: shared FSM states, channel count and mode encodings
package demux_dispatcher_pkg;
    localparam int N_CH = 4;
    localparam logic MODE_RR = 1'b0;
    localparam logic MODE_ADDR = 1'b1;
    typedef enum logic {EMPTY, PENDING} state_e;
endpackage

// File: rtl/demux_dispatcher_if.sv
// demux_dispatcher_if: upstream, downstream, control and status signals of the dispatcher
interface demux_dispatcher_if #(parameter int CNT_W = 4);
    import demux_dispatcher_pkg::*;
    logic in_valid, in_data, in_ready, mode, out_valid, din, s1, s0, out_ready, drop;
    logic [1:0] in_addr;
    logic [N_CH-1:0] ch_en;
    logic [N_CH*CNT_W-1:0] cnt;
    modport master(
        output in_valid, in_data, in_addr, mode, ch_en, out_ready,
        input in_ready, out_valid, din, s1, s0, cnt, drop
    );
    modport slave(
        input in_valid, in_data, in_addr, mode, ch_en, out_ready,
        output in_ready, out_valid, din, s1, s0, cnt, drop
    );
endinterface

// File: rtl/demux_dispatcher_rr_pick.sv
// rr_pick: first enabled channel after ptr, searching ptr+1 .. ptr+4 with wrap
module rr_pick
    import demux_dispatcher_pkg::*;
(
    input  logic [1:0]      ptr_i,
    input  logic [N_CH-1:0] mask_i,
    output logic [1:0]      index_o,
    output logic            found_o
);
    // Scanning from farthest to nearest leaves the nearest enabled channel last
    always_comb begin
        index_o = '0;
        for (int k = N_CH; k >= 1; k--)
            if (mask_i[ptr_i + 2'(k)]) index_o = ptr_i + 2'(k);
        found_o = |mask_i;
    end
endmodule

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: routes accepted bits to a 1:4 demux through one output register
module demux_dispatcher
    import demux_dispatcher_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input logic clk,
    input logic rst,
    demux_dispatcher_if.slave bus
);
    state_e state_q, state_d;
    logic din_q, din_d, rdy, acc, load, tx_out, rr_found;
    logic [1:0] sel_q, sel_d, ptr_q, ptr_d, rr_idx, sel;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    rr_pick u_pick (
        .ptr_i(ptr_q),
        .mask_i(bus.ch_en),
        .index_o(rr_idx),
        .found_o(rr_found)
    );

    // A round-robin pick is always enabled, so only addressed items can drop
    always_comb begin
        sel = (bus.mode == MODE_ADDR) ? bus.in_addr : rr_idx;
        tx_out = (state_q == PENDING) && bus.out_ready;
        rdy = !rst && (state_q == EMPTY || bus.out_ready) && (bus.mode == MODE_ADDR || rr_found);
        acc = bus.in_valid && rdy;
        load = acc && bus.ch_en[sel];
        state_d = load ? PENDING : tx_out ? EMPTY : state_q;
        din_d = load ? bus.in_data : tx_out ? 1'b0 : din_q;
        sel_d = load ? sel : tx_out ? 2'd0 : sel_q;
        ptr_d = (acc && bus.mode == MODE_RR) ? rr_idx : ptr_q;
        cnt_d = cnt_q;
        if (tx_out && cnt_q[sel_q] != '1) cnt_d[sel_q] = cnt_q[sel_q] + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            din_q <= 1'b0;
            sel_q <= 2'd0;
            ptr_q <= 2'd3;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            din_q <= din_d;
            sel_q <= sel_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready = rdy;
    assign bus.drop = acc && !load;
    assign bus.out_valid = (state_q == PENDING);
    assign bus.din = din_q;
    assign bus.s1 = sel_q[1];
    assign bus.s0 = sel_q[0];
    assign bus.cnt = cnt_q;
endmodule

// File: tb/tb_demux_dispatcher.sv
// tb_demux_dispatcher: random and directed stimulus with a queue scoreboard and reference model
module tb_demux_dispatcher;
    localparam int CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_dispatcher_if #(.CNT_W(CNT_W)) bus();
    demux_dispatcher #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [2:0] sb[$];
    int mcnt[4];
    bit pend = 0;
    int ptr = 3;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic cyc(bit r, bit v, bit d, bit [1:0] a, bit m, bit [3:0] en, bit ordy);
        bit rdy;
        int ch;
        @(posedge clk);
        #1;
        rst = r;
        bus.in_valid = v;
        bus.in_data = d;
        bus.in_addr = a;
        bus.mode = m;
        bus.ch_en = en;
        bus.out_ready = ordy;
        @(negedge clk);
        chk("out_valid", bus.out_valid, pend);
        if (!pend) chk("idle_outputs", {bus.din, bus.s1, bus.s0}, 0);
        rdy = !r && (!pend || ordy) && (m || en != 0);
        chk("in_ready", bus.in_ready, rdy);
        ch = -1;
        if (v && rdy) begin
            if (!m) begin
                for (int k = 1; k <= 4; k++)
                    if (en[(ptr + k) % 4]) begin
                        ch = (ptr + k) % 4;
                        break;
                    end
                ptr = ch;
            end else if (en[a]) ch = a;
        end
        chk("drop", bus.drop, v && rdy && m && !en[a]);
        if (ch >= 0) sb.push_back({ch[1:0], d});
        if (r) begin
            pend = 0;
            ptr = 3;
            sb.delete();
            for (int c = 0; c < 4; c++) mcnt[c] = 0;
        end else pend = (ch >= 0) ? 1'b1 : (pend && ordy) ? 1'b0 : pend;
    endtask

    // Monitor: counters reflect transfers seen on earlier cycles; the queue front must sit on the outputs
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) chk($sformatf("cnt%0d", c), bus.cnt[c*CNT_W +: CNT_W], mcnt[c]);
            if (bus.out_valid) begin
                if (sb.size() == 0) chk("unexpected_item", bus.out_valid, 0);
                else begin
                    chk("din", bus.din, sb[0][0]);
                    chk("channel", {bus.s1, bus.s0}, sb[0][2:1]);
                    if (bus.out_ready) begin
                        if (mcnt[sb[0][2:1]] < CMAX) mcnt[sb[0][2:1]]++;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit [3:0] data = 4'b1101;
        for (int c = 0; c < 4; c++) mcnt[c] = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.in_addr = 0;
        bus.mode = 0; bus.ch_en = 4'hF; bus.out_ready = 1;
        cyc(1, 1, 0, 0, 0, 4'hF, 1);
        cyc(1, 0, 0, 0, 0, 4'hF, 1);
        // Round robin over all channels, data 1,0,1,1
        for (int i = 0; i < 4; i++) cyc(0, 1, data[i], 0, 0, 4'hF, 1);
        cyc(0, 0, 0, 0, 0, 4'hF, 1);
        // Sparse mask alternates channels 0 and 2
        for (int i = 0; i < 4; i++) cyc(0, 1, i[0], 0, 0, 4'b0101, 1);
        cyc(0, 0, 0, 0, 0, 4'hF, 1);
        // Backpressure on a pending channel-1 item
        cyc(0, 1, 1, 1, 1, 4'hF, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 2, i[0], 4'h0, 0);
        cyc(0, 0, 0, 0, 1, 4'hF, 1);
        // Addressed to a disabled channel drops, then an enabled one delivers
        cyc(0, 1, 1, 3, 1, 4'b0111, 1);
        cyc(0, 1, 1, 2, 1, 4'b0111, 1);
        cyc(0, 0, 0, 0, 1, 4'b0111, 1);
        // Round robin with nothing enabled accepts nothing
        cyc(0, 1, 1, 0, 0, 4'h0, 1);
        // Saturation of channel 0
        for (int i = 0; i < 20; i++) cyc(0, 1, i[0], 0, 1, 4'hF, 1);
        cyc(0, 0, 0, 0, 1, 4'hF, 1);
        // Reset while pending, then round robin restarts at channel 0
        cyc(0, 1, 1, 1, 0, 4'hF, 0);
        cyc(0, 0, 0, 0, 0, 4'hF, 0);
        cyc(1, 1, 0, 0, 0, 4'hF, 1);
        cyc(0, 1, 1, 0, 0, 4'hF, 1);
        cyc(0, 0, 0, 0, 0, 4'hF, 1);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                2'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
                $urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 4'hF, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_dispatcher.md
DEMUX_DISPATCHER -- requirements
Module: demux_dispatcher

Interface
REQ-001 CNT_W, 4, width of each per-channel delivery counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers a data bit.
REQ-005 in_data  input  1  data bit offered.
REQ-006 in_addr  input  2  target channel, used in addressed mode only.
REQ-007 in_ready  output  1  dispatcher accepts the offered bit this cycle.
REQ-008 mode  input  1  0 = round-robin, 1 = addressed.
REQ-009 ch_en  input  4  per-channel enable mask, bit n = channel n.
REQ-010 out_valid  output  1  din/s1/s0 hold a pending item for the downstream 1:4 demux.
REQ-011 din  output  1  data bit to the demux.
REQ-012 s1, s0  output  1 each  channel select to the demux, {s1,s0} = channel index.
REQ-013 out_ready  input  1  downstream consumes the pending item.
REQ-014 cnt  output  4*CNT_W  delivery counters, channel n at bits [n*CNT_W +: CNT_W].
REQ-015 drop  output  1  one-cycle pulse when an accepted item is discarded.

Function
REQ-016 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-017 Single output register stage; accepted item appears on din/s1/s0 with out_valid=1 the cycle after acceptance (latency 1).
REQ-018 in_ready = (!out_valid || out_ready) && (mode==1 || ch_en!=0); full throughput of one item per cycle when out_ready stays high.
REQ-019 FSM states EMPTY (out_valid=0) and PENDING (out_valid=1); EMPTY->PENDING on routed accept; PENDING->EMPTY on transfer out without a new routed accept; PENDING->PENDING on simultaneous out and routed in (register reloads).
REQ-020 While PENDING and out_ready=0, din, s1, s0 are held stable.
REQ-021 Round-robin: pointer holds last channel used; selected channel is first enabled channel searching ptr+1, ptr+2, ptr+3, ptr (mod 4, wrap 3->0); pointer updates to the selected channel on accept.
REQ-022 Round-robin with ch_en==0: in_ready=0, nothing accepted, pointer unchanged.
REQ-023 Addressed: selected channel = in_addr; pointer unchanged.
REQ-024 Addressed to a disabled channel: item is accepted (in_ready per REQ-018), not loaded, drop=1 for that cycle, FSM state follows as if no accept.
REQ-025 ch_en or mode changes while PENDING do not alter the pending item.
REQ-026 On transfer out, counter of channel {s1,s0} increments by 1, saturating at 2^CNT_W-1.
REQ-027 Only out_valid=1 cycles are meaningful on din/s1/s0; when EMPTY, din=0, s1=0, s0=0.

Reset
REQ-028 rst=1 at a clock edge: out_valid=0, din=0, s1=0, s0=0, all counters 0, drop=0, pointer=3 (first round-robin pick is channel 0), state EMPTY.
REQ-029 Reset mid-operation discards any pending item without counting it; in_ready is 0 while rst=1.

Structure
REQ-030 Shared package holds the state enum (EMPTY, PENDING), the channel-count constant 4 and the mode encodings.
REQ-031 One sub-module, rr_pick: combinational 4-way next-enabled-channel finder (inputs ptr, mask; outputs index, found).

Verification
REQ-032 Reset, then mode=0, ch_en=1111, in_valid=1 with data 1,0,1,1, out_ready=1 -> out_valid from cycle 1, {s1,s0}=0,1,2,3, din=1,0,1,1, cnt each 1.
REQ-033 mode=0, ch_en=0101, 4 items -> channels 0,2,0,2; cnt0=2, cnt2=2, cnt1=cnt3=0.
REQ-034 out_ready=0 for 3 cycles with item pending on channel 1, din=1 -> in_ready=0, outputs stable, counters unchanged; out_ready=1 -> cnt1+1 same edge.
REQ-035 mode=1, in_addr=3, ch_en=0111 -> drop pulses 1 cycle, out_valid stays 0, cnt3 unchanged; in_addr=2 -> delivered on channel 2.
REQ-036 20 deliveries to channel 0 with CNT_W=4 -> cnt0 saturates at 15.
REQ-037 rst asserted while PENDING -> next cycle out_valid=0, all counters 0, next round-robin item goes to channel 0.
